computie_bus_trigger_snooper: RTL and testbench
===============================================

COMPUTIE_BUS_TRIGGER_SNOOPER -- requirements
Module: computie_bus_trigger_snooper

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, width of cb_addr_data_bus.
REQ-002 SHALL have parameter DEPTH, default 16, record buffer entries; must be a power of two and at least 4.
REQ-003 SHALL have parameter PRE_TRIGGER, default 4, records retained before trigger; must be less than DEPTH.
REQ-004 SHALL have one clock and reset, with reset synchronous and active-high: comm_clock input 1, rising-edge clock; comm_reset input 1, synchronous active-high reset.
REQ-005 SHALL have these bus inputs, all asynchronous to comm_clock: cb_addr_strobe input 1, active-low address strobe; cb_data_strobe input 1, active-low data strobe; cb_read_write input 1, 1 = read; cb_addr_data_bus input BITWIDTH, multiplexed address/data bus.
REQ-006 SHALL have these control inputs: record_start input 1, level-sensitive arm; record_mode input 1, 0 = single-shot, 1 = continuous; record_trigger input 1, manual trigger pulse.
REQ-007 SHALL have these match inputs: match_addr input BITWIDTH; match_mask input BITWIDTH, 1 = bit compared; match_rw_en input 1; match_rw input 1.
REQ-008 SHALL have these record outputs: record_valid output 1; record_ready input 1; record_out output 2*BITWIDTH+1, {rw, addr, data}.
REQ-009 SHALL have these status outputs: record_end output 1, capture complete and drained; record_triggered output 1; record_overflow output 1, sticky drop flag.

Function
REQ-010 SHALL pass strobes, rw and bus through identical 2-flop synchronizers, keeping bus and strobes aligned.
REQ-011 SHALL latch address and rw on the synchronized cb_addr_strobe 1->0 edge.
REQ-012 SHALL latch data every cycle while synchronized cb_data_strobe is low, excluding the address-edge cycle; the last value wins.
REQ-013 SHALL form a record on the synchronized cb_addr_strobe 0->1 edge: 3 comm_clock cycles after the pin edge, the record is written to the buffer.
REQ-014 SHALL define a match as (((addr ^ match_addr) & match_mask) == 0) && (!match_rw_en || rw == match_rw).
REQ-015 SHALL use states IDLE, ARMED, TRIGGERED, DONE.
REQ-016 SHALL handle IDLE: buffer empty, no writes; record_start=1 -> ARMED, clearing record_triggered, record_overflow and record_end.
REQ-017 SHALL handle ARMED: records written, no output (record_valid=0); count capped at PRE_TRIGGER by discarding the oldest on write.
REQ-018 SHALL leave ARMED for TRIGGERED on a matching record, which is stored, or on a record_trigger pulse, where the next record is the first post-trigger record.
REQ-019 SHALL set record_triggered on the transition to TRIGGERED.
REQ-020 SHALL behave as a first-word-fall-through FIFO in TRIGGERED and DONE: record_valid = not empty; record_out is stable while record_valid && !record_ready; a transfer occurs when record_valid && record_ready.
REQ-021 SHALL, in single-shot mode, move to DONE after DEPTH-PRE_TRIGGER post-trigger records, counting the trigger record; DONE accepts no writes.
REQ-022 SHALL assert record_end in DONE once the buffer is empty, holding it until record_start=0.
REQ-023 SHALL, in continuous mode, remain in TRIGGERED writing records indefinitely.
REQ-024 SHALL, on a write to a full buffer in TRIGGERED, drop the record and set record_overflow sticky.
REQ-025 SHALL allow a simultaneous write and read: both occur and the count is unchanged; a full buffer with a same-cycle read is not an overflow.
REQ-026 SHALL, on record_start=0 in any state, go to IDLE on the next cycle, flush the buffer and deassert record_valid and record_end; record_triggered and record_overflow hold until re-armed.
REQ-027 SHALL ignore record_trigger outside ARMED.

Reset
REQ-028 SHALL, on comm_reset, enter IDLE, empty the buffer, zero the pointers and synchronizers (strobes to 1), and drive record_valid, record_end, record_triggered and record_overflow to 0 and record_out to 0.
REQ-029 SHALL treat reset mid-capture identically, discarding any partial record.

Verification (DEPTH=8, PRE_TRIGGER=2)
REQ-030 SHALL cover reset: comm_reset for 2 cycles with bus active -> all status outputs 0, record_valid=0, no record emitted.
REQ-031 SHALL cover match trigger: match_addr=0x20200000, mask=0xFFFF0000, rw_en=0; writes to 0x10000000, 0x10000004, 0x10000008, then write 0x2020FFFF data 0xAAAAAAAA -> outputs {0,0x10000004,..}, {0,0x10000008,..}, {0,0x2020FFFF,0xAAAAAAAA}; record_triggered=1.
REQ-032 SHALL cover single-shot: continue with 5 more cycles and then 2 extras -> exactly 8 records out, extras absent; record_end=1 after the last transfer.
REQ-033 SHALL cover a manual read: record_trigger pulse in ARMED, then AS and DS low together with bus 0x12345678, then 0x55555555 -> record_out={1,0x12345678,0x55555555}.
REQ-034 SHALL cover overflow: continuous mode, record_ready=0, 10 cycles after trigger -> 8 stored, record_overflow=1; drain order oldest-first.
REQ-035 SHALL cover abort: record_start dropped with 3 records queued -> record_valid=0 next cycle; re-arm gives empty buffer and cleared flags.

Source files
------------

// File: rtl/computie_bus_trigger_snooper.sv
// Bus snooper for the Computie multiplexed address/data bus: synchronises the bus, forms one record
// per address-strobe cycle and captures around a trigger into a first-word-fall-through buffer.
module computie_bus_trigger_snooper #(
  parameter int unsigned BITWIDTH    = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PRE_TRIGGER = 4
) (
  input  logic                  comm_clock,
  input  logic                  comm_reset,
  input  logic                  cb_addr_strobe,
  input  logic                  cb_data_strobe,
  input  logic                  cb_read_write,
  input  logic [BITWIDTH-1:0]   cb_addr_data_bus,
  input  logic                  record_start,
  input  logic                  record_mode,
  input  logic                  record_trigger,
  input  logic [BITWIDTH-1:0]   match_addr,
  input  logic [BITWIDTH-1:0]   match_mask,
  input  logic                  match_rw_en,
  input  logic                  match_rw,
  output logic                  record_valid,
  input  logic                  record_ready,
  output logic [2*BITWIDTH:0]   record_out,
  output logic                  record_end,
  output logic                  record_triggered,
  output logic                  record_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 2 * BITWIDTH + 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PreCnt  = (AW + 1)'(PRE_TRIGGER);
  localparam logic [AW:0] PostCnt = (AW + 1)'(DEPTH - PRE_TRIGGER);

  typedef enum logic [1:0] {StIdle, StArmed, StTriggered, StDone} state_e;

  // Synchronisers: every bus pin gets the same two-flop delay so strobes and bus stay aligned.
  logic                as_s1_q, as_s2_q, as_prev_q;
  logic                ds_s1_q, ds_s2_q;
  logic                rw_s1_q, rw_s2_q;
  logic [BITWIDTH-1:0] bus_s1_q, bus_s2_q;

  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      as_s1_q   <= 1'b1;
      as_s2_q   <= 1'b1;
      as_prev_q <= 1'b1;
      ds_s1_q   <= 1'b1;
      ds_s2_q   <= 1'b1;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      bus_s1_q  <= '0;
      bus_s2_q  <= '0;
    end else begin
      as_s1_q   <= cb_addr_strobe;
      as_s2_q   <= as_s1_q;
      as_prev_q <= as_s2_q;
      ds_s1_q   <= cb_data_strobe;
      ds_s2_q   <= ds_s1_q;
      rw_s1_q   <= cb_read_write;
      rw_s2_q   <= rw_s1_q;
      bus_s1_q  <= cb_addr_data_bus;
      bus_s2_q  <= bus_s1_q;
    end
  end

  // Record assembly
  logic                as_fall, as_rise, data_upd;
  logic                open_q, open_d;
  logic                rwc_q, rwc_d;
  logic [BITWIDTH-1:0] addr_q, addr_d, data_q, data_d, rec_data;
  logic [RW-1:0]       rec;
  logic                rec_valid, is_match;

  assign as_fall  = as_prev_q & ~as_s2_q;
  assign as_rise  = ~as_prev_q & as_s2_q;
  assign data_upd = ~ds_s2_q & ~as_fall;

  always_comb begin
    open_d = open_q;
    rwc_d  = rwc_q;
    addr_d = addr_q;
    data_d = data_q;
    if (as_fall) begin
      open_d = 1'b1;
      rwc_d  = rw_s2_q;
      addr_d = bus_s2_q;
      data_d = '0;
    end else if (data_upd) begin
      data_d = bus_s2_q;
    end
    if (as_rise) begin
      open_d = 1'b0;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      open_q <= 1'b0;
      rwc_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      open_q <= open_d;
      rwc_q  <= rwc_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // A data beat coinciding with the strobe release still belongs to this record.
  assign rec_data  = data_upd ? bus_s2_q : data_q;
  assign rec       = {rwc_q, addr_q, rec_data};
  assign rec_valid = as_rise & open_q;
  assign is_match  = (((addr_q ^ match_addr) & match_mask) == '0) &&
                     (!match_rw_en || (rwc_q == match_rw));

  // Capture FSM and buffer pointers
  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, post_q, post_d;
  logic          trig_q, trig_d, ovf_q, ovf_d, end_q, end_d;
  logic          wr_en, drop_oldest, rd_en, pop, flush;
  logic [RW-1:0] mem_q [DEPTH];

  assign record_valid = ((state_q == StTriggered) || (state_q == StDone)) && (count_q != '0);
  assign rd_en        = record_valid & record_ready;
  assign pop          = rd_en | drop_oldest;

  always_comb begin
    state_d     = state_q;
    post_d      = post_q;
    trig_d      = trig_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    drop_oldest = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (record_start) begin
          state_d = StArmed;
          trig_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StArmed: begin
        if (rec_valid && is_match) begin
          wr_en   = 1'b1;
          trig_d  = 1'b1;
          post_d  = (AW + 1)'(1);
          state_d = (!record_mode && (PostCnt == (AW + 1)'(1))) ? StDone : StTriggered;
        end else begin
          // Pre-trigger history is a sliding window: the oldest entry goes when it is full.
          if (rec_valid && (PreCnt != '0)) begin
            wr_en       = 1'b1;
            drop_oldest = (count_q == PreCnt);
          end
          if (record_trigger) begin
            state_d = StTriggered;
            trig_d  = 1'b1;
            post_d  = '0;
          end
        end
      end
      StTriggered: begin
        if (rec_valid) begin
          if ((count_q == FullCnt) && !rd_en) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
          if (!record_mode) begin
            post_d = post_q + 1'b1;
            if (post_d == PostCnt) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase
    if (!record_start) begin
      state_d     = StIdle;
      wr_en       = 1'b0;
      drop_oldest = 1'b0;
      flush       = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    end_d = (state_d == StDone) && (count_d == '0);
  end

  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
      trig_q   <= trig_d;
      ovf_q    <= ovf_d;
      end_q    <= end_d;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (wr_en && !comm_reset) begin
      mem_q[wr_ptr_q] <= rec;
    end
  end

  assign record_out       = record_valid ? mem_q[rd_ptr_q] : '0;
  assign record_end       = end_q;
  assign record_triggered = trig_q;
  assign record_overflow  = ovf_q;

endmodule

// File: tb/tb_computie_bus_trigger_snooper.sv
// Directed bench for the bus trigger snooper (DEPTH=8, PRE_TRIGGER=2).
module tb_computie_bus_trigger_snooper;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_n, ds_n, rw, start, mode, trig, ready, m_rw_en, m_rw;
  logic [31:0] bus, m_addr, m_mask;
  logic        valid, rend, triggered, overflow;
  logic [64:0] rout;

  logic [64:0] got[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  computie_bus_trigger_snooper #(
    .BITWIDTH   (32),
    .DEPTH      (8),
    .PRE_TRIGGER(2)
  ) dut (
    .comm_clock      (clk),
    .comm_reset      (rst),
    .cb_addr_strobe  (as_n),
    .cb_data_strobe  (ds_n),
    .cb_read_write   (rw),
    .cb_addr_data_bus(bus),
    .record_start    (start),
    .record_mode     (mode),
    .record_trigger  (trig),
    .match_addr      (m_addr),
    .match_mask      (m_mask),
    .match_rw_en     (m_rw_en),
    .match_rw        (m_rw),
    .record_valid    (valid),
    .record_ready    (ready),
    .record_out      (rout),
    .record_end      (rend),
    .record_triggered(triggered),
    .record_overflow (overflow)
  );

  // Every accepted transfer is logged; ready only changes just after a rising edge.
  always @(negedge clk) begin
    if (!rst && valid && ready) got.push_back(rout);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return '1;
  endfunction

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic r);
    bus  = a;
    rw   = r;
    as_n = 1'b0;
    tick(3);
    bus  = d;
    ds_n = 1'b0;
    tick(3);
    ds_n = 1'b1;
    tick(1);
    as_n = 1'b1;
    tick(5);
  endtask

  task automatic pulse_trigger();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  initial begin
    as_n = 1'b1; ds_n = 1'b1; rw = 1'b0; bus = '0;
    start = 1'b0; mode = 1'b0; trig = 1'b0; ready = 1'b1;
    m_addr = 32'h2020_0000; m_mask = 32'hFFFF_0000; m_rw_en = 1'b0; m_rw = 1'b0;

    // Reset with the bus active
    rst = 1'b1; as_n = 1'b0; ds_n = 1'b0; bus = 32'hDEAD_BEEF;
    tick(2);
    rst = 1'b0; as_n = 1'b1; ds_n = 1'b1;
    tick(3);
    chk("rst_valid", 65'(valid), 65'(0));
    chk("rst_status", 65'({rend, triggered, overflow}), 65'(0));
    chk("rst_out", rout, 65'(0));
    chk("rst_no_record", 65'(got.size()), 65'(0));

    // Match trigger, single-shot
    start = 1'b1;
    tick(2);
    bus_xfer(32'h1000_0000, 32'h11, 1'b0);
    bus_xfer(32'h1000_0004, 32'h22, 1'b0);
    bus_xfer(32'h1000_0008, 32'h33, 1'b0);
    chk("armed_no_valid", 65'(valid), 65'(0));
    bus_xfer(32'h2020_FFFF, 32'hAAAA_AAAA, 1'b0);
    tick(3);
    chk("match_cnt", 65'(got.size()), 65'(3));
    chk("match_rec0", got_at(0), {1'b0, 32'h1000_0004, 32'h22});
    chk("match_rec1", got_at(1), {1'b0, 32'h1000_0008, 32'h33});
    chk("match_rec2", got_at(2), {1'b0, 32'h2020_FFFF, 32'hAAAA_AAAA});
    chk("match_trig", 65'(triggered), 65'(1));
    chk("match_no_end", 65'(rend), 65'(0));

    for (int i = 0; i < 5; i++) bus_xfer(32'h3000_0000 + 32'(4 * i), 32'(i), 1'b0);
    bus_xfer(32'h4000_0000, 32'hEE, 1'b0);
    bus_xfer(32'h4000_0004, 32'hFF, 1'b0);
    tick(3);
    chk("single_cnt", 65'(got.size()), 65'(8));
    chk("single_rec3", got_at(3), {1'b0, 32'h3000_0000, 32'h0});
    chk("single_rec7", got_at(7), {1'b0, 32'h3000_0010, 32'h4});
    chk("single_end", 65'(rend), 65'(1));
    chk("single_valid", 65'(valid), 65'(0));
    start = 1'b0;
    tick(1);
    chk("stop_end_clr", 65'(rend), 65'(0));
    chk("stop_trig_hold", 65'(triggered), 65'(1));

    // Manual trigger, then a read cycle with both strobes dropping together
    got.delete();
    start = 1'b1;
    tick(2);
    chk("rearm_trig_clr", 65'(triggered), 65'(0));
    pulse_trigger();
    chk("manual_trig", 65'(triggered), 65'(1));
    rw = 1'b1; bus = 32'h1234_5678; as_n = 1'b0; ds_n = 1'b0;
    tick(1);
    bus = 32'h5555_5555;
    tick(3);
    as_n = 1'b1; ds_n = 1'b1;
    tick(6);
    rw = 1'b0;
    chk("manual_cnt", 65'(got.size()), 65'(1));
    chk("manual_rec", got_at(0), {1'b1, 32'h1234_5678, 32'h5555_5555});
    start = 1'b0;
    tick(2);

    // Overflow in continuous mode with the consumer stalled
    got.delete();
    mode = 1'b1; ready = 1'b0; start = 1'b1;
    tick(2);
    pulse_trigger();
    for (int i = 0; i < 10; i++) bus_xfer(32'h0000_0500 + 32'(4 * i), 32'(i), 1'b0);
    chk("ovf_flag", 65'(overflow), 65'(1));
    chk("ovf_valid", 65'(valid), 65'(1));
    chk("ovf_head_stable", rout, {1'b0, 32'h500, 32'h0});
    ready = 1'b1;
    tick(10);
    chk("ovf_cnt", 65'(got.size()), 65'(8));
    chk("ovf_first", got_at(0), {1'b0, 32'h500, 32'h0});
    chk("ovf_last", got_at(7), {1'b0, 32'h51C, 32'h7});
    start = 1'b0;
    tick(2);
    chk("ovf_hold", 65'(overflow), 65'(1));

    // Abort with three records queued, then re-arm
    got.delete();
    ready = 1'b0; start = 1'b1;
    tick(2);
    chk("rearm_ovf_clr", 65'(overflow), 65'(0));
    pulse_trigger();
    for (int i = 0; i < 3; i++) bus_xfer(32'h0000_0600 + 32'(4 * i), 32'(i), 1'b0);
    chk("abort_pre_valid", 65'(valid), 65'(1));
    start = 1'b0;
    tick(1);
    chk("abort_valid", 65'(valid), 65'(0));
    chk("abort_trig_hold", 65'(triggered), 65'(1));
    start = 1'b1;
    tick(1);
    chk("abort_rearm_flags", 65'({rend, triggered, overflow}), 65'(0));
    ready = 1'b1;
    tick(3);
    chk("abort_empty", 65'(got.size()), 65'(0));
    chk("abort_empty_valid", 65'(valid), 65'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
